// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, in-flight PC tags, instruction buffer to decode.
// Response-to-out_valid latency 1; stalls requests when buffer occupancy plus outstanding reaches BUF_DEPTH.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_vld) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_vld)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_vld) - CW'(pop_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_opcode,
  output logic [31:0] out_pc
);
  localparam int CW  = $clog2(BUF_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] opcode;
  } inst_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] buf_cnt, ifq_cnt;
  logic [31:0]   ifq_pc;
  inst_t         buf_in, buf_out;
  logic [CW:0]   inflight, credit_used;
  logic          req_fire, rsp_any, rsp_drop, rsp_keep, out_fire;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // Responses still owed by memory include those already marked for dropping.
  assign inflight    = {1'b0, ifq_cnt} + {1'b0, drop_cnt_q};
  assign credit_used = inflight + {1'b0, buf_cnt};

  always_comb begin
    imem_req_valid = resetn && !redirect_valid && (credit_used < CW1'(BUF_DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_any        = imem_rsp_valid && (inflight != '0);
    rsp_drop       = rsp_any && (drop_cnt_q != '0);
    rsp_keep       = rsp_any && (drop_cnt_q == '0) && !redirect_valid;
    out_valid      = resetn && !redirect_valid && (buf_cnt != '0);
    out_fire       = out_valid && out_ready;
    buf_in.pc      = ifq_pc;
    buf_in.opcode  = imem_rsp_data;
    out_opcode     = buf_out.opcode;
    out_pc         = buf_out.pc;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_cnt_d = inflight[CW-1:0] - CW'(rsp_any);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && imem_rsp_valid) assert (inflight != '0);
  end

  fetch_fifo #(.W(32), .DEPTH(BUF_DEPTH)) u_ifq (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (redirect_valid),
    .push_vld (req_fire),
    .push_dat (fetch_pc_q),
    .pop_vld  (rsp_keep),
    .pop_dat  (ifq_pc),
    .cnt      (ifq_cnt)
  );

  fetch_fifo #(.W($bits(inst_t)), .DEPTH(BUF_DEPTH)) u_ibuf (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (redirect_valid),
    .push_vld (rsp_keep),
    .push_dat (buf_in),
    .pop_vld  (out_fire),
    .pop_dat  (buf_out),
    .cnt      (buf_cnt)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, ready stall, PC wrap, mid-stream reset.
module tb_fetch_unit;
  logic        clk;
  logic        resetn;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_opcode, out_pc;

  logic        d2_req_valid, d2_out_valid;
  logic [31:0] d2_req_addr, d2_out_opcode, d2_out_pc;
  logic        tie_one, tie_zero;
  logic [31:0] tie_word;

  logic        rsp_hold;
  logic [31:0] pend[$];
  int          n_chk, n_pass, fires;
  logic [31:0] last_addr;

  fetch_unit u_dut (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_pc(out_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(d2_req_valid), .imem_req_ready(tie_one), .imem_req_addr(d2_req_addr),
    .imem_rsp_valid(tie_zero), .imem_rsp_data(tie_word),
    .redirect_valid(tie_zero), .redirect_pc(tie_word),
    .out_valid(d2_out_valid), .out_ready(tie_one), .out_opcode(d2_out_opcode), .out_pc(d2_out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // In-order memory: answers the cycle after acceptance unless held.
  always @(posedge clk) begin
    if (!resetn) begin
      pend.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
      if (!rsp_hold && pend.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= word(pend.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    resetn = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    out_ready = 1'b1; rsp_hold = 1'b0;
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    tie_one = 1'b1; tie_zero = 1'b0; tie_word = 32'h0;
    resetn = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b1; rsp_hold = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_req_vld", imem_req_valid, 32'd0);
    check_eq("rst_out_vld", out_valid, 32'd0);
    check_eq("rst_wrap_req_vld", d2_req_valid, 32'd0);

    // streaming: one request and one instruction per cycle, PC wrap on second instance
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      check_eq("seq_req_vld", imem_req_valid, 32'd1);
      check_eq("seq_addr", imem_req_addr, 32'(4 * k));
      if (k < 3) check_eq("wrap_addr", d2_req_addr, 32'hFFFF_FFF8 + 32'(4 * k));
      if (k >= 2) begin
        check_eq("seq_out_vld", out_valid, 32'd1);
        check_eq("seq_out_pc", out_pc, 32'(4 * (k - 2)));
        check_eq("seq_opcode", out_opcode, word(32'(4 * (k - 2))));
      end else begin
        check_eq("seq_out_vld_early", out_valid, 32'd0);
      end
    end

    // decode stalled: buffer fills, exactly four requests, then drains in order
    do_reset(1);
    out_ready = 1'b0;
    fires = 0; last_addr = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      if (imem_req_valid && imem_req_ready) begin
        fires++;
        last_addr = imem_req_addr;
      end
    end
    check_eq("stall_fires", 32'(fires), 32'd4);
    check_eq("stall_last_addr", last_addr, 32'h0000_000C);
    check_eq("stall_req_vld", imem_req_valid, 32'd0);
    check_eq("stall_out_vld", out_valid, 32'd1);
    check_eq("stall_out_pc_held", out_pc, 32'h0);
    nxt(); out_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      check_eq("drain_out_vld", out_valid, 32'd1);
      check_eq("drain_out_pc", out_pc, 32'(4 * i));
      check_eq("drain_opcode", out_opcode, word(32'(4 * i)));
      if (i == 1) begin
        check_eq("resume_req_vld", imem_req_valid, 32'd1);
        check_eq("resume_addr", imem_req_addr, 32'h0000_0010);
      end
    end

    // memory not ready: address held
    do_reset(1);
    cyc();
    nxt(); imem_req_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      check_eq("hold_req_vld", imem_req_valid, 32'd1);
      check_eq("hold_addr", imem_req_addr, 32'h0000_0008);
    end
    nxt(); imem_req_ready = 1'b1; #1;
    check_eq("hold_accept_addr", imem_req_addr, 32'h0000_0008);
    cyc();
    check_eq("hold_next_addr", imem_req_addr, 32'h0000_000C);

    // redirect with two outstanding requests
    do_reset(1);
    rsp_hold = 1'b1;
    cyc();
    check_eq("redir_pre_addr", imem_req_addr, 32'h0000_0004);
    nxt(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_1002; #1;
    check_eq("redir_req_vld", imem_req_valid, 32'd0);
    check_eq("redir_out_vld", out_valid, 32'd0);
    nxt(); redirect_valid = 1'b0; imem_req_ready = 1'b1; rsp_hold = 1'b0; #1;
    check_eq("redir_req_vld_after", imem_req_valid, 32'd1);
    check_eq("redir_addr", imem_req_addr, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("redir_drop_out_vld", out_valid, 32'd0);
    end
    cyc();
    check_eq("redir_first_vld", out_valid, 32'd1);
    check_eq("redir_first_pc", out_pc, 32'h0000_1000);
    check_eq("redir_first_op", out_opcode, word(32'h0000_1000));
    cyc();
    check_eq("redir_second_pc", out_pc, 32'h0000_1004);

    // one-cycle reset with the buffer full
    do_reset(1);
    out_ready = 1'b0;
    repeat (7) cyc();
    check_eq("full_out_vld", out_valid, 32'd1);
    check_eq("full_req_vld", imem_req_valid, 32'd0);
    nxt(); resetn = 1'b0; #1;
    check_eq("midrst_req_vld", imem_req_valid, 32'd0);
    check_eq("midrst_out_vld", out_valid, 32'd0);
    nxt(); resetn = 1'b1; out_ready = 1'b1; #1;
    check_eq("postrst_out_vld", out_valid, 32'd0);
    check_eq("postrst_req_vld", imem_req_valid, 32'd1);
    check_eq("postrst_addr", imem_req_addr, 32'h0);
    cyc();
    cyc();
    check_eq("postrst_first_vld", out_valid, 32'd1);
    check_eq("postrst_first_pc", out_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (word-aligned).
REQ-002 SHALL have parameter BUF_DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  fetch address, bits[1:0]=0.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order, >=1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  taken branch/jump from memory stage.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port out_valid  output  1  opcode/PC valid to decode.
REQ-013 SHALL have port out_ready  input  1  decode accepts.
REQ-014 SHALL have port out_opcode  output  32  instruction to decode (opcode).
REQ-015 SHALL have port out_pc  output  32  PC of out_opcode (pc_in).

Function
REQ-016 SHALL hold fetch_pc; request accepted when imem_req_valid && imem_req_ready; fetch_pc += 4 on acceptance, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-017 SHALL drive imem_req_addr = fetch_pc combinationally.
REQ-018 SHALL assert imem_req_valid iff resetn=1, redirect_valid=0, and (buffer occupancy + outstanding requests) < BUF_DEPTH.
REQ-019 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 SHALL keep an in-order in-flight PC queue (depth BUF_DEPTH) tagging each accepted request.
REQ-021 SHALL push {in-flight PC, imem_rsp_data} into the instruction FIFO on imem_rsp_valid when drop count is zero; visible at out_* next cycle (response-to-out_valid latency 1).
REQ-022 SHALL drive out_valid = (FIFO not empty) && !redirect_valid; out_opcode/out_pc from FIFO head, held stable until handshake.
REQ-023 SHALL pop on out_valid && out_ready; push and pop same cycle allowed, occupancy unchanged.
REQ-024 SHALL, on redirect_valid=1: flush FIFO, set fetch_pc = {redirect_pc[31:2],2'b00}, set drop count = outstanding requests (excluding any response arriving that cycle), clear in-flight queue.
REQ-025 SHALL discard responses while drop count > 0, decrementing by one per response; normal pushes resume when zero.
REQ-026 SHALL let redirect win over simultaneous response, pop or request; no request is issued in a redirect cycle.
REQ-027 SHALL ignore imem_rsp_valid with no outstanding request (simulation assertion flags it).
REQ-028 SHALL sustain one instruction per cycle with 1-cycle imem latency, imem_req_ready=1, out_ready=1.
REQ-029 SHALL never overflow the FIFO (credit rule REQ-018 guarantees space for every outstanding response).

Reset
REQ-030 SHALL, while resetn=0 at a rising edge, set fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop count=0.
REQ-031 SHALL drive imem_req_valid=0 and out_valid=0 throughout any cycle with resetn=0; out_opcode/out_pc are don't-care.
REQ-032 SHALL abandon in-flight requests on reset mid-operation; responses arriving after reset release are treated per REQ-027.

Verification
REQ-033 Reset release, imem 1-cycle latency, ready=1 -> addr 0x0,0x4,0x8 on consecutive cycles; out_pc 0x0 at cycle 2, then one per cycle, opcodes match memory.
REQ-034 out_ready=0 held -> exactly 4 requests issued (0x0..0xC), imem_req_valid drops; release -> 4 pops in order, fetching resumes at 0x10.
REQ-035 Redirect to 0x0000_1002 with 2 outstanding -> next 2 responses dropped, next request addr 0x1000, out_valid=0 in redirect cycle, first out_pc=0x1000.
REQ-036 imem_req_ready=0 for 3 cycles -> addr held at 0x8, no PC advance; then continues 0xC.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 resetn=0 for 1 cycle mid-stream with FIFO full -> out_valid=0 next cycle, next request addr=RESET_PC.
